// File: rtl/btn_pkg.sv
// btn_pkg: shared FSM encoding and limit helper for the push-button setpoint block
package btn_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, RPT = 2'd2} st_e;
  localparam int LW = 33;
  function automatic logic [LW-1:0] clamp(input logic [LW-1:0] v, input logic [LW-1:0] lo, input logic [LW-1:0] hi);
    return v < lo ? lo : (v > hi ? hi : v);
  endfunction
endpackage

// File: rtl/btn_setpt_if.sv
// btn_setpt_if: button, load and setpoint signals between board logic and btn_setpt
interface btn_setpt_if #(parameter int WIDTH = 16);
  logic btn_u, btn_d, ld;
  logic [WIDTH-1:0] ld_val, val;
  logic step_u, step_d, lim;
  modport master(output btn_u, btn_d, ld, ld_val, input val, step_u, step_d, lim);
  modport slave(input btn_u, btn_d, ld, ld_val, output val, step_u, step_d, lim);
endinterface

// File: rtl/btn_rpt.sv
// btn_rpt: synchronise, debounce and auto-repeat one active-low button into step requests
module btn_rpt import btn_pkg::*; #(
  parameter int unsigned DEB_CYC = 65535,
  parameter int unsigned HOLD_CYC = 25000000,
  parameter int unsigned RPT_CYC = 5000000
) (
  input logic clk,
  input logic rst_n,
  input logic btn_n,
  output logic step
);
  localparam int DW = $clog2(DEB_CYC + 1);
  localparam int CW = $clog2((HOLD_CYC > RPT_CYC ? HOLD_CYC : RPT_CYC) + 1);
  logic [1:0] sy;
  logic prs, deb_done, step_n;
  logic [DW-1:0] dcnt;
  logic [CW-1:0] cnt, cnt_n;
  st_e st, st_n;
  assign deb_done = sy[1] != prs && dcnt == DW'(DEB_CYC - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sy <= '0;
      prs <= 1'b0;
      dcnt <= '0;
      st <= IDLE;
      cnt <= '0;
      step <= 1'b0;
    end else begin
      sy <= {sy[0], ~btn_n};
      dcnt <= (sy[1] == prs || deb_done) ? '0 : dcnt + 1'b1;
      prs <= deb_done ? sy[1] : prs;
      st <= st_n;
      cnt <= cnt_n;
      step <= step_n;
    end
  always_comb begin
    st_n = st;
    cnt_n = cnt;
    step_n = 1'b0;
    case (st)
      IDLE: if (prs) begin
        step_n = 1'b1;
        cnt_n = '0;
        st_n = HOLD;
      end
      HOLD: if (!prs) st_n = IDLE;
      else if (cnt == CW'(HOLD_CYC - 1)) begin
        step_n = 1'b1;
        cnt_n = '0;
        st_n = RPT;
      end else cnt_n = cnt + 1'b1;
      RPT: if (!prs) st_n = IDLE;
      else if (cnt == CW'(RPT_CYC - 1)) begin
        step_n = 1'b1;
        cnt_n = '0;
      end else cnt_n = cnt + 1'b1;
      default: st_n = IDLE;
    endcase
  end
endmodule

// File: rtl/btn_setpt.sv
// btn_setpt: bounded setpoint adjusted by debounced up/down buttons with auto-repeat and load
module btn_setpt import btn_pkg::*; #(
  parameter int WIDTH = 16,
  parameter int unsigned MIN_VAL = 0,
  parameter int unsigned MAX_VAL = 16'hFFFF,
  parameter int unsigned STEP = 1,
  parameter bit WRAP = 1'b0,
  parameter int unsigned DEB_CYC = 65535,
  parameter int unsigned HOLD_CYC = 25000000,
  parameter int unsigned RPT_CYC = 5000000,
  parameter int unsigned RST_VAL = 0
) (
  input logic clk,
  input logic rst_n,
  btn_setpt_if.slave bus
);
  localparam logic [WIDTH:0] MN = (WIDTH+1)'(MIN_VAL);
  localparam logic [WIDTH:0] MX = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0] ST = (WIDTH+1)'(STEP);
  logic ru, rd, nu, nd, nl;
  logic [WIDTH-1:0] nv, ld_c;
  btn_rpt #(.DEB_CYC(DEB_CYC), .HOLD_CYC(HOLD_CYC), .RPT_CYC(RPT_CYC)) u_up (
    .clk(clk), .rst_n(rst_n), .btn_n(bus.btn_u), .step(ru));
  btn_rpt #(.DEB_CYC(DEB_CYC), .HOLD_CYC(HOLD_CYC), .RPT_CYC(RPT_CYC)) u_dn (
    .clk(clk), .rst_n(rst_n), .btn_n(bus.btn_d), .step(rd));
  assign ld_c = WIDTH'(clamp(LW'(bus.ld_val), LW'(MIN_VAL), LW'(MAX_VAL)));
  // compares run one bit wider than val so limits at 0 and 2^WIDTH-1 cannot overflow
  always_comb begin
    nv = bus.val;
    nu = 1'b0;
    nd = 1'b0;
    nl = 1'b0;
    if (bus.ld) begin
      nv = ld_c;
      nl = ld_c != bus.ld_val;
    end else if (ru && !rd) begin
      nu = 1'b1;
      nl = {1'b0, bus.val} + ST > MX;
      nv = !nl ? bus.val + WIDTH'(STEP) : (WRAP ? WIDTH'(MIN_VAL) : WIDTH'(MAX_VAL));
    end else if (rd && !ru) begin
      nd = 1'b1;
      nl = {1'b0, bus.val} < MN + ST;
      nv = !nl ? bus.val - WIDTH'(STEP) : (WRAP ? WIDTH'(MAX_VAL) : WIDTH'(MIN_VAL));
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.val <= WIDTH'(RST_VAL);
      bus.step_u <= 1'b0;
      bus.step_d <= 1'b0;
      bus.lim <= 1'b0;
    end else begin
      bus.val <= nv;
      bus.step_u <= nu;
      bus.step_d <= nd;
      bus.lim <= nl;
    end
endmodule

// File: tb/tb_btn_setpt.sv
// tb_btn_setpt: directed checks of btn_setpt in saturate (d0) and wrap (d1) configurations
module tb_btn_setpt;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  btn_setpt_if #(.WIDTH(8)) u0();
  btn_setpt_if #(.WIDTH(8)) u1();
  btn_setpt #(.WIDTH(8), .MIN_VAL(10), .MAX_VAL(20), .STEP(3), .WRAP(1'b0), .DEB_CYC(4),
    .HOLD_CYC(8), .RPT_CYC(4), .RST_VAL(10)) d0 (.clk(clk), .rst_n(rst_n), .bus(u0));
  btn_setpt #(.WIDTH(8), .MIN_VAL(10), .MAX_VAL(20), .STEP(3), .WRAP(1'b1), .DEB_CYC(4),
    .HOLD_CYC(8), .RPT_CYC(4), .RST_VAL(10)) d1 (.clk(clk), .rst_n(rst_n), .bus(u1));
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    tick();
    checks++;
    if ({u0.val, u0.step_u, u0.step_d, u0.lim} !== {8'd10, 3'b000}) begin
      errors++;
      $display("FAIL reset d0 got val=%0d su=%b sd=%b lim=%b want val=10 pulses=0", u0.val, u0.step_u, u0.step_d, u0.lim);
    end
    checks++;
    if ({u1.val, u1.step_u, u1.step_d, u1.lim} !== {8'd10, 3'b000}) begin
      errors++;
      $display("FAIL reset d1 got val=%0d su=%b sd=%b lim=%b want val=10 pulses=0", u1.val, u1.step_u, u1.step_d, u1.lim);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    logic [7:0] ev;
    do_reset();
    u0.btn_u = 1'b0;
    for (int c = 1; c <= 25; c++) begin
      tick();
      if (c == 6) u0.btn_u = 1'b1;
      ev = c >= 8 ? 8'd13 : 8'd10;
      checks++;
      if ({u0.val, u0.step_u, u0.step_d, u0.lim} !== {ev, c == 8, 2'b00}) begin
        errors++;
        $display("FAIL single c=%0d got val=%0d su=%b sd=%b lim=%b want val=%0d su=%b", c, u0.val, u0.step_u, u0.step_d, u0.lim, ev, c == 8);
      end
    end
  endtask

  task automatic test_bounce();
    do_reset();
    for (int c = 0; c < 30; c++) begin
      u0.btn_u = (c < 20) ? (((c / 2) % 2) != 0) : 1'b1;
      tick();
      checks++;
      if ({u0.val, u0.step_u, u0.lim} !== {8'd10, 2'b00}) begin
        errors++;
        $display("FAIL bounce c=%0d got val=%0d su=%b lim=%b want val=10 su=0 lim=0", c, u0.val, u0.step_u, u0.lim);
      end
    end
  endtask

  task automatic test_repeat_sat();
    logic [7:0] ev;
    logic es;
    do_reset();
    u0.btn_u = 1'b0;
    for (int c = 1; c <= 55; c++) begin
      tick();
      if (c == 40) u0.btn_u = 1'b1;
      es = c == 8 || (c >= 16 && c <= 44 && c % 4 == 0);
      ev = c < 8 ? 8'd10 : c < 16 ? 8'd13 : c < 20 ? 8'd16 : c < 24 ? 8'd19 : 8'd20;
      checks++;
      if ({u0.val, u0.step_u, u0.step_d, u0.lim} !== {ev, es, 1'b0, es && c >= 24}) begin
        errors++;
        $display("FAIL repeat c=%0d got val=%0d su=%b lim=%b want val=%0d su=%b lim=%b", c, u0.val, u0.step_u, u0.lim, ev, es, es && c >= 24);
      end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] ev;
    do_reset();
    u1.btn_d = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == 6) u1.btn_d = 1'b1;
      ev = c >= 8 ? 8'd20 : 8'd10;
      checks++;
      if ({u1.val, u1.step_u, u1.step_d, u1.lim} !== {ev, 1'b0, c == 8, c == 8}) begin
        errors++;
        $display("FAIL wrap c=%0d got val=%0d sd=%b lim=%b want val=%0d sd=lim=%b", c, u1.val, u1.step_d, u1.lim, ev, c == 8);
      end
    end
  endtask

  task automatic test_both();
    do_reset();
    u0.btn_u = 1'b0;
    u0.btn_d = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (c == 30) begin
        u0.btn_u = 1'b1;
        u0.btn_d = 1'b1;
      end
      checks++;
      if ({u0.val, u0.step_u, u0.step_d, u0.lim} !== {8'd10, 3'b000}) begin
        errors++;
        $display("FAIL both c=%0d got val=%0d su=%b sd=%b lim=%b want val=10 pulses=0", c, u0.val, u0.step_u, u0.step_d, u0.lim);
      end
    end
  endtask

  task automatic test_load();
    logic [7:0] lv [3] = '{8'd200, 8'd15, 8'd3};
    logic [7:0] ev [3] = '{8'd20, 8'd15, 8'd10};
    logic el [3] = '{1'b1, 1'b0, 1'b1};
    do_reset();
    u0.btn_u = 1'b0;
    repeat (7) tick();
    for (int i = 0; i < 3; i++) begin
      u0.ld = 1'b1;
      u0.ld_val = lv[i];
      tick();
      checks++;
      if ({u0.val, u0.step_u, u0.step_d, u0.lim} !== {ev[i], 2'b00, el[i]}) begin
        errors++;
        $display("FAIL load ld_val=%0d got val=%0d su=%b lim=%b want val=%0d su=0 lim=%b", lv[i], u0.val, u0.step_u, u0.lim, ev[i], el[i]);
      end
    end
    u0.ld = 1'b0;
    repeat (6) tick();
    checks++;
    if ({u0.val, u0.step_u, u0.lim} !== {8'd13, 2'b10}) begin
      errors++;
      $display("FAIL load_then_step got val=%0d su=%b lim=%b want val=13 su=1 lim=0", u0.val, u0.step_u, u0.lim);
    end
    u0.btn_u = 1'b1;
    repeat (12) tick();
  endtask

  task automatic test_reset_hold();
    logic [7:0] ev;
    do_reset();
    u0.btn_u = 1'b0;
    repeat (30) tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({u0.val, u0.step_u, u0.lim} !== {8'd10, 2'b00}) begin
      errors++;
      $display("FAIL async_reset got val=%0d su=%b lim=%b want val=10 su=0 lim=0", u0.val, u0.step_u, u0.lim);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      ev = c >= 8 ? 8'd13 : 8'd10;
      checks++;
      if ({u0.val, u0.step_u} !== {ev, c == 8}) begin
        errors++;
        $display("FAIL reset_hold c=%0d got val=%0d su=%b want val=%0d su=%b", c, u0.val, u0.step_u, ev, c == 8);
      end
    end
    u0.btn_u = 1'b1;
    repeat (12) tick();
  endtask

  initial begin
    u0.btn_u = 1'b1;
    u0.btn_d = 1'b1;
    u0.ld = 1'b0;
    u0.ld_val = '0;
    u1.btn_u = 1'b1;
    u1.btn_d = 1'b1;
    u1.ld = 1'b0;
    u1.ld_val = '0;
    test_reset();
    test_single();
    test_bounce();
    test_repeat_sat();
    test_wrap();
    test_both();
    test_load();
    test_reset_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
